// File: rtl/ibuf.sv
// rtl/ibuf.sv - pad input buffer with pass-through, synchroniser, glitch filter and edge pulses
module ibuf #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             osc,
  input  logic             rst,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] O_sync,
  output logic [WIDTH-1:0] O_filt,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  assign O = I;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [SYNC_STAGES-1:0] chain;
    logic [7:0]             cnt;
    logic                   filt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_bit;

    assign sync_bit = chain[SYNC_STAGES-1];

    always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], I[b]};
      end
    end

    // Edge pulses are registered alongside the filtered level so they line up with its change.
    always_ff @(posedge osc or posedge rst) begin
      if (rst) begin
        cnt    <= 8'd0;
        filt_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync_bit == filt_q) begin
          cnt <= 8'd0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= 8'd0;
          filt_q <= sync_bit;
          rise_q <= sync_bit;
          fall_q <= ~sync_bit;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end

    assign O_sync[b] = sync_bit;
    assign O_filt[b] = filt_q;
    assign rise[b]   = rise_q;
    assign fall[b]   = fall_q;
  end

endmodule

// File: tb/tb_ibuf.sv
// tb/tb_ibuf.sv - randomized self-checking bench for ibuf against a history-based model
module tb_ibuf;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int FL_A = 3;
  localparam int FL_B = 1;

  logic         osc = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [W-1:0] I   = '0;

  logic [W-1:0] o_a, sync_a, filt_a, rise_a, fall_a;
  logic [W-1:0] o_b, sync_b, filt_b, rise_b, fall_b;

  ibuf #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL_A)) dut_a (
    .osc(osc), .rst(rst), .I(I), .O(o_a), .O_sync(sync_a),
    .O_filt(filt_a), .rise(rise_a), .fall(fall_a)
  );

  ibuf #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL_B)) dut_b (
    .osc(osc), .rst(rst), .I(I), .O(o_b), .O_sync(sync_b),
    .O_filt(filt_b), .rise(rise_b), .fall(fall_b)
  );

  always begin
    #5;
    if (run) osc = ~osc;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Model: O_sync is the input sample taken SS edges ago; the filtered level flips once
  // the last FL O_sync samples (seen since reset) all disagree with it.
  logic [W-1:0] iq[$];
  logic [W-1:0] hist [2][8];
  int           nh [2];
  int           fl [2] = '{FL_A, FL_B};
  logic [W-1:0] m_filt [2];
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];

  task automatic model_reset();
    iq.delete();
    for (int i = 0; i < SS; i++) iq.push_back('0);
    for (int k = 0; k < 2; k++) begin
      nh[k] = 0;
      m_filt[k] = '0;
      m_rise[k] = '0;
      m_fall[k] = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    logic         all;
    s = iq[0];
    for (int k = 0; k < 2; k++) begin
      for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = s;
      if (nh[k] < 8) nh[k]++;
      m_rise[k] = '0;
      m_fall[k] = '0;
      for (int b = 0; b < W; b++) begin
        if (nh[k] >= fl[k]) begin
          all = 1'b1;
          for (int j = 0; j < fl[k]; j++)
            if (hist[k][j][b] == m_filt[k][b]) all = 1'b0;
          if (all) begin
            m_filt[k][b] = ~m_filt[k][b];
            m_rise[k][b] = m_filt[k][b];
            m_fall[k][b] = ~m_filt[k][b];
          end
        end
      end
    end
    iq.push_back(I);
    void'(iq.pop_front());
  endtask

  task automatic check_all();
    check("O_a", 8'(o_a), 8'(I));
    check("O_b", 8'(o_b), 8'(I));
    check("sync_a", 8'(sync_a), 8'(iq[0]));
    check("sync_b", 8'(sync_b), 8'(iq[0]));
    check("filt_a", 8'(filt_a), 8'(m_filt[0]));
    check("filt_b", 8'(filt_b), 8'(m_filt[1]));
    check("rise_a", 8'(rise_a), 8'(m_rise[0]));
    check("rise_b", 8'(rise_b), 8'(m_rise[1]));
    check("fall_a", 8'(fall_a), 8'(m_fall[0]));
    check("fall_b", 8'(fall_b), 8'(m_fall[1]));
  endtask

  task automatic cycle();
    @(posedge osc);
    model_edge();
    @(negedge osc);
    check_all();
  endtask

  int n;

  initial begin
    model_reset();
    // Clock stopped, reset held: only the pass-through moves.
    for (int i = 0; i < 6; i++) begin
      I = W'($urandom);
      #3;
      check_all();
    end
    I = '0;
    #2;
    rst = 1'b0;
    run = 1'b1;
    repeat (4) cycle();

    // Clean step up then down: five edges each way with default depths.
    I = '1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (filt_a !== '1 && n < 20);
    check("lat_rise", 8'(n), 8'(SS + FL_A));
    repeat (3) cycle();
    I = '0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (filt_a !== '0 && n < 20);
    check("lat_fall", 8'(n), 8'(SS + FL_A));
    repeat (3) cycle();

    // Directed multi-bit pattern for the FILTER_LEN=1 instance.
    I = 4'b1010;
    repeat (5) cycle();
    I = 4'b0101;
    repeat (5) cycle();

    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 2) == 0) I = W'($urandom);
      cycle();
      if ($urandom_range(0, 59) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        I = W'($urandom);
        #1;
        check_all();
        rst = 1'b0;
      end
    end

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
